// File: rtl/gpc_sum_tree_if.sv
// Beat-in / result-out channel of the GPC sum tree.
// N, W and ACC_EXT must match the parameters of the attached gpc_sum_tree.
interface gpc_sum_tree_if #(
  parameter int N       = 9,
  parameter int W       = 8,
  parameter int ACC_EXT = 8
);
  localparam int OW = W + $clog2(N) + ACC_EXT;

  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  in_data;
  logic            in_acc;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_data;
  logic            out_ovf;

  // master: the beat source and result sink around the block
  modport master (
    output in_valid, in_data, in_acc, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  // slave: the sum tree itself
  modport slave (
    input  in_valid, in_data, in_acc, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/gpc_sum_tree.sv
// Pipelined multi-operand unsigned adder: (3;2) GPC carry-save levels, a final
// carry-propagate add, and a running accumulator with sticky overflow.
module gpc_sum_tree #(
  parameter int N       = 9,
  parameter int W       = 8,
  parameter int PIPE    = 2,
  parameter int ACC_EXT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  gpc_sum_tree_if.slave bus
);
  localparam int OW = W + $clog2(N) + ACC_EXT;

  // Bit heap: up to N rows of OW bits; rows beyond the live count stay zero.
  typedef logic [N-1:0][OW-1:0] heap_t;

  function automatic int next_rows(input int rows);
    return (rows / 3) * 2 + (rows % 3);
  endfunction

  function automatic int num_levels();
    int r;
    int l;
    r = N;
    l = 0;
    for (int i = 0; i < 32; i++) begin
      if (r > 2) begin
        r = next_rows(r);
        l++;
      end
    end
    return l;
  endfunction

  function automatic int rows_at(input int lvl);
    int r;
    r = N;
    for (int i = 0; i < lvl; i++) r = next_rows(r);
    return r;
  endfunction

  localparam int L = num_levels();

  // Boundary b sits after b compressor levels (b = 0 is the raw operands).
  // PIPE registers are spread over boundaries 0..L; the first always
  // captures the accepted beat, the output register follows the final add.
  function automatic int stage_pos(input int k);
    return (k * (L + 1)) / PIPE;
  endfunction

  function automatic int regs_at(input int b);
    int c;
    c = 0;
    for (int k = 0; k < PIPE; k++) begin
      if (stage_pos(k) == b) c++;
    end
    return c;
  endfunction

  // One level of full-adder columns: every 3 live rows become sum + carry.
  // Carries shifted past bit OW-1 are dropped; the exact total fits in OW bits.
  function automatic heap_t csa_level(input heap_t x, input int rows);
    heap_t y;
    int    groups;
    int    rest;
    y      = '0;
    groups = rows / 3;
    rest   = rows % 3;
    for (int g = 0; g < N / 3; g++) begin
      if (g < groups) begin
        y[2*g]   = x[3*g] ^ x[3*g+1] ^ x[3*g+2];
        y[2*g+1] = ((x[3*g] & x[3*g+1]) | (x[3*g] & x[3*g+2]) |
                    (x[3*g+1] & x[3*g+2])) << 1;
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (r < rest) y[2*groups+r] = x[3*groups+r];
    end
    return y;
  endfunction

  function automatic logic [OW-1:0] cpa_sum(input heap_t x);
    return x[0] + x[1];
  endfunction

  // Flow control: one shared stall. A beat moves on an edge where
  // in_valid & in_ready; a result leaves where out_valid & out_ready.
  // in_ready is purely ~stall and never looks at in_valid; every stage,
  // including the output register, holds while stalled.
  logic stall;
  logic adv;

  assign stall        = bus.out_valid & ~bus.out_ready;
  assign adv          = ~stall;
  assign bus.in_ready = adv;

  for (genvar b = 0; b <= L; b++) begin : g_bnd
    localparam int RC = regs_at(b);

    heap_t d_pre;
    logic  v_pre;
    logic  a_pre;
    heap_t d_post;
    logic  v_post;
    logic  a_post;

    if (b == 0) begin : g_src
      always_comb begin
        d_pre = '0;
        for (int i = 0; i < N; i++) d_pre[i] = OW'(bus.in_data[i*W +: W]);
      end
      assign v_pre = bus.in_valid;
      assign a_pre = bus.in_acc;
    end else begin : g_lvl
      assign d_pre = csa_level(g_bnd[b-1].d_post, rows_at(b - 1));
      assign v_pre = g_bnd[b-1].v_post;
      assign a_pre = g_bnd[b-1].a_post;
    end

    if (RC == 0) begin : g_wire
      assign d_post = d_pre;
      assign v_post = v_pre;
      assign a_post = a_pre;
    end else begin : g_reg
      heap_t         d_q [RC];
      logic [RC-1:0] v_q;
      logic [RC-1:0] a_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= '0;
          a_q <= '0;
          for (int i = 0; i < RC; i++) d_q[i] <= '0;
        end else if (adv) begin
          v_q[0] <= v_pre;
          a_q[0] <= a_pre;
          d_q[0] <= d_pre;
          for (int i = 1; i < RC; i++) begin
            v_q[i] <= v_q[i-1];
            a_q[i] <= a_q[i-1];
            d_q[i] <= d_q[i-1];
          end
        end
      end

      assign d_post = d_q[RC-1];
      assign v_post = v_q[RC-1];
      assign a_post = a_q[RC-1];
    end
  end

  logic [OW-1:0] sum_w;
  logic [OW:0]   acc_sum;
  logic          out_valid_q;
  logic [OW-1:0] out_data_q;
  logic          out_ovf_q;

  // The output register doubles as the accumulator: acc always equals the
  // last loaded result.
  assign sum_w   = cpa_sum(g_bnd[L].d_post);
  assign acc_sum = {1'b0, out_data_q} + {1'b0, sum_w};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= g_bnd[L].v_post;
      if (g_bnd[L].v_post) begin
        if (g_bnd[L].a_post) begin
          out_data_q <= acc_sum[OW-1:0];
          out_ovf_q  <= out_ovf_q | acc_sum[OW];
        end else begin
          out_data_q <= sum_w;
          out_ovf_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_gpc_sum_tree.sv
// Bench for gpc_sum_tree: directed vectors on the default configuration and
// randomised beats on three corner configurations against a behavioural sum.
module tb_gpc_sum_tree;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  bit   sweep_go;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- default configuration: N=9 W=8 PIPE=2 ACC_EXT=8 (OW=20)
  gpc_sum_tree_if #(.N(9), .W(8), .ACC_EXT(8)) mb ();
  gpc_sum_tree #(.N(9), .W(8), .PIPE(2), .ACC_EXT(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mb)
  );

  logic [63:0] exp_q[$];

  function automatic logic [63:0] pack(input logic ovf, input logic [19:0] d);
    return {43'd0, ovf, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input logic acc);
    for (int i = 0; i < 9; i++) mb.in_data[i*8 +: 8] = v;
    mb.in_acc   = acc;
    mb.in_valid = 1'b1;
    @(negedge clk);
    check("in_ready", 64'(mb.in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && mb.out_valid && mb.out_ready) begin
      check("main_q", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("main_out", {43'd0, mb.out_ovf, mb.out_data}, exp_q.pop_front());
    end
  end

  // ---------------- sweep configurations
  for (genvar c = 0; c < 3; c++) begin : g_sw
    localparam int SN  = (c == 0) ? 2 : (c == 1) ? 32 : 9;
    localparam int SW  = (c == 0) ? 1 : (c == 1) ? 32 : 8;
    localparam int SP  = (c == 0) ? 1 : (c == 1) ? 4 : 3;
    localparam int SA  = (c == 2) ? 0 : 8;
    localparam int SOW = SW + $clog2(SN) + SA;

    gpc_sum_tree_if #(.N(SN), .W(SW), .ACC_EXT(SA)) sb ();
    gpc_sum_tree #(.N(SN), .W(SW), .PIPE(SP), .ACC_EXT(SA)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sb)
    );

    logic [63:0]    sq[$];
    int             lq[$];
    bit             done;
    bit             pending;
    bit             adv_nxt;
    int             adv;
    logic [SOW-1:0] m_acc;
    logic           m_ovf;
    logic [SOW:0]   s;
    logic [SOW:0]   r;

    initial begin : drive
      done        = 1'b0;
      pending     = 1'b0;
      adv_nxt     = 1'b0;
      adv         = 0;
      m_acc       = '0;
      m_ovf       = 1'b0;
      sb.in_valid = 1'b0;
      sb.in_acc   = 1'b0;
      sb.in_data  = '0;
      sb.out_ready = 1'b1;
      wait (sweep_go);
      @(posedge clk);
      #1;
      for (int cyc = 0; cyc < 150; cyc++) begin
        if (!pending) begin
          sb.in_valid = ($urandom_range(0, 3) != 0);
          sb.in_acc   = ($urandom_range(0, 1) != 0);
          for (int i = 0; i < SN; i++) sb.in_data[i*SW +: SW] = SW'($urandom);
          pending = sb.in_valid;
        end
        sb.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (sb.in_valid && sb.in_ready) begin
          s = '0;
          for (int i = 0; i < SN; i++) s = s + (SOW+1)'(sb.in_data[i*SW +: SW]);
          if (sb.in_acc) begin
            r     = {1'b0, m_acc} + s;
            m_ovf = m_ovf | r[SOW];
          end else begin
            r     = s;
            m_ovf = 1'b0;
          end
          m_acc = r[SOW-1:0];
          sq.push_back(64'({m_ovf, m_acc}));
          lq.push_back(adv + 1);
          pending = 1'b0;
        end
        @(posedge clk);
        #1;
      end
      sb.in_valid  = 1'b0;
      sb.out_ready = 1'b1;
      for (int i = 0; i < 40 && sq.size() != 0; i++) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("sw%0d_drain", c), 64'(sq.size()), 64'd0);
      done = 1'b1;
    end

    always @(negedge clk) begin : mon
      if (sweep_go && rst_n && sb.out_valid && sb.out_ready) begin
        check($sformatf("sw%0d_q", c), 64'(sq.size() != 0), 64'd1);
        if (sq.size() != 0) begin
          check($sformatf("sw%0d_data", c), 64'({sb.out_ovf, sb.out_data}), sq.pop_front());
          check($sformatf("sw%0d_lat", c), 64'(adv), 64'(lq.pop_front() + SP));
        end
      end
      adv_nxt = !(sb.out_valid && !sb.out_ready);
    end

    always @(posedge clk) begin : cnt
      if (adv_nxt) adv++;
    end
  end

  // ---------------- directed sequence
  initial begin : main
    logic [31:0] prod;
    total        = 0;
    bad          = 0;
    sweep_go     = 1'b0;
    rst_n        = 1'b0;
    mb.in_valid  = 1'b0;
    mb.in_acc    = 1'b0;
    mb.in_data   = '0;
    mb.out_ready = 1'b1;

    // reset state
    #12;
    check("rst_valid", 64'(mb.out_valid), 64'd0);
    check("rst_data", 64'(mb.out_data), 64'd0);
    check("rst_ovf", 64'(mb.out_ovf), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(mb.in_ready), 64'd1);
    tick();

    // single beat of all 0xFF: 9*255 = 2295, visible after edge k+2 only
    exp_q.push_back(pack(1'b0, 20'd2295));
    send(8'hFF, 1'b0);
    mb.in_valid = 1'b0;
    check("t1_v_k0", 64'(mb.out_valid), 64'd0);
    tick();
    check("t1_v_k1", 64'(mb.out_valid), 64'd0);
    tick();
    check("t1_v_k2", 64'(mb.out_valid), 64'd1);
    check("t1_data", 64'(mb.out_data), 64'd2295);
    check("t1_ovf", 64'(mb.out_ovf), 64'd0);
    tick();
    check("t1_v_k3", 64'(mb.out_valid), 64'd0);

    // back-to-back 1s, 2s, 3s -> 9, 18, 27 on consecutive cycles
    exp_q.push_back(pack(1'b0, 20'd9));
    exp_q.push_back(pack(1'b0, 20'd18));
    exp_q.push_back(pack(1'b0, 20'd27));
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    mb.in_valid = 1'b0;
    check("t2_v0", 64'(mb.out_valid), 64'd1);
    check("t2_d0", 64'(mb.out_data), 64'd9);
    tick();
    check("t2_d1", 64'(mb.out_data), 64'd18);
    tick();
    check("t2_d2", 64'(mb.out_data), 64'd27);
    tick();
    check("t2_idle", 64'(mb.out_valid), 64'd0);

    // accumulate run of 2295 per beat: beat i -> i*2295 mod 2^20, ovf from beat 457
    for (int i = 1; i <= 458; i++) begin
      prod = i * 2295;
      exp_q.push_back(pack(i >= 457, prod[19:0]));
      send(8'hFF, i != 1);
    end
    exp_q.push_back(pack(1'b0, 20'd9));
    send(8'd1, 1'b0);
    mb.in_valid = 1'b0;
    repeat (4) tick();
    check("acc_drain", 64'(exp_q.size()), 64'd0);

    // stall: 4s, 5s, 6s in flight, 7s offered during a 5-cycle stall
    mb.out_ready = 1'b0;
    exp_q.push_back(pack(1'b0, 20'd36));
    exp_q.push_back(pack(1'b0, 20'd45));
    exp_q.push_back(pack(1'b0, 20'd54));
    exp_q.push_back(pack(1'b0, 20'd63));
    send(8'd4, 1'b0);
    send(8'd5, 1'b0);
    send(8'd6, 1'b0);
    for (int i = 0; i < 9; i++) mb.in_data[i*8 +: 8] = 8'd7;
    mb.in_acc   = 1'b0;
    mb.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_ready", 64'(mb.in_ready), 64'd0);
      check("t3_valid", 64'(mb.out_valid), 64'd1);
      check("t3_hold", 64'(mb.out_data), 64'd36);
      tick();
    end
    mb.out_ready = 1'b1;
    @(negedge clk);
    check("t3_release", 64'(mb.in_ready), 64'd1);
    tick();
    mb.in_valid = 1'b0;
    check("t3_next", 64'(mb.out_data), 64'd45);
    repeat (4) tick();
    check("t3_drain", 64'(exp_q.size()), 64'd0);

    // asynchronous reset with two beats in flight
    mb.out_ready = 1'b0;
    send(8'd8, 1'b0);
    send(8'd9, 1'b0);
    mb.in_valid = 1'b0;
    tick();
    check("t4_stalled", 64'(mb.out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t4_async_valid", 64'(mb.out_valid), 64'd0);
    check("t4_async_data", 64'(mb.out_data), 64'd0);
    check("t4_async_ovf", 64'(mb.out_ovf), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    mb.out_ready = 1'b1;
    @(negedge clk);
    check("t4_ready", 64'(mb.in_ready), 64'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t4_no_stale", 64'(mb.out_valid), 64'd0);
      tick();
    end
    exp_q.push_back(pack(1'b0, 20'd9));
    send(8'd1, 1'b1);
    mb.in_valid = 1'b0;
    repeat (4) tick();
    check("t4_drain", 64'(exp_q.size()), 64'd0);

    // corner configurations
    sweep_go = 1'b1;
    for (int i = 0; i < 3000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); i++) begin
      @(posedge clk);
    end
    check("sweep_done", 64'(g_sw[0].done && g_sw[1].done && g_sw[2].done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
